// File: rtl/bus_arb.sv
// Two-master arbiter for the shared 8-bit data bus (CPU = m0, loader = m1).
// Define BUS_ARB_RR_EN for round-robin ties; default is fixed m0 priority.
module bus_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   tie_m1;

`ifdef BUS_ARB_RR_EN
  assign tie_m1 = ~last;
`else
  assign tie_m1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (m0_ack)
        last <= 1'b0;
      else if (m1_ack)
        last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req)
          state_nxt = tie_m1 ? OWN1 : OWN0;
        else if (m0_req)
          state_nxt = OWN0;
        else if (m1_req)
          state_nxt = OWN1;
        else
          state_nxt = IDLE;
      end
      OWN0: begin
        m0_ack    = m0_req;
        m0_rdata  = m0_req ? bus_rdata : '0;
        bus_we    = m0_req & m0_we;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
`ifdef BUS_ARB_RR_EN
        if (m1_req)
          state_nxt = OWN1;
        else if (m0_req)
          state_nxt = OWN0;
        else
          state_nxt = IDLE;
`else
        // m1 waits until the CPU stops requesting
        if (m0_req)
          state_nxt = OWN0;
        else if (m1_req)
          state_nxt = OWN1;
        else
          state_nxt = IDLE;
`endif
      end
      OWN1: begin
        m1_ack    = m1_req;
        m1_rdata  = m1_req ? bus_rdata : '0;
        bus_we    = m1_req & m1_we;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        if (m1_req && m1_lock)
          state_nxt = OWN1;
        else if (m0_req)
          state_nxt = OWN0;
        else if (m1_req)
          state_nxt = OWN1;
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_stall = m0_req & ~m0_ack;
  assign owner    = state;

endmodule

// File: tb/tb_bus_arb.sv
// Randomized bench for bus_arb against a rule-level ownership model.
// Memory model behind the bus is a 256-byte array shadowed by the checker.
module tb_bus_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m0_ack, m0_stall;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_ack, m1_lock;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic       bus_we;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0] owner;

  always #5 clk = ~clk;

  bus_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .owner(owner)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'(i) ^ 8'h4A;
  endfunction

  logic [7:0] mem [256];
  assign bus_rdata = mem[bus_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus_we) begin
      mem[bus_addr] <= bus_wdata;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: owner 0 idle / 1 m0 / 2 m1, last acked master
  int         m_own;
  int         m_last;
  int         m_next;
  logic [7:0] ref_mem [256];
  bit         e_ack0, e_ack1, e_we;
  logic [7:0] e_addr, e_wdata;

  task automatic model_reset();
    m_own  = 0;
    m_last = 1;
    e_ack0 = 0;
    e_ack1 = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic check_cycle();
    bit r0, r1;
    r0 = m0_req;
    r1 = m1_req;
    e_ack0  = (m_own == 1) && r0;
    e_ack1  = (m_own == 2) && r1;
    e_addr  = (m_own == 1) ? m0_addr : m1_addr;
    e_wdata = (m_own == 1) ? m0_wdata : m1_wdata;
    e_we    = (e_ack0 && m0_we) || (e_ack1 && m1_we);
    chk("owner", 32'(owner), 32'(m_own));
    chk("m0_ack", 32'(m0_ack), 32'(e_ack0));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack1));
    chk("m0_stall", 32'(m0_stall), 32'(r0 && !e_ack0));
    chk("bus_we", 32'(bus_we), 32'(e_we));
    chk("m0_rdata", 32'(m0_rdata),
        e_ack0 ? 32'(ref_mem[m0_addr]) : 32'd0);
    chk("m1_rdata", 32'(m1_rdata),
        e_ack1 ? 32'(ref_mem[m1_addr]) : 32'd0);
    if (e_ack0 || e_ack1) chk("bus_addr", 32'(bus_addr), 32'(e_addr));
    if (e_we) chk("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
    if (m_own == 0 && !(e_ack0 || e_ack1)) begin
      chk("idle_addr", 32'(bus_addr), 32'd0);
    end
    // ownership rules
    if (m_own == 2 && r1 && m1_lock)
      m_next = 2;
    else if (m_own == 0 && r0 && r1)
`ifdef BUS_ARB_RR_EN
      m_next = (m_last == 1) ? 1 : 2;
`else
      m_next = 1;
`endif
`ifdef BUS_ARB_RR_EN
    else if (m_own == 1 && r1)
      m_next = 2;
`endif
    else if (r0)
      m_next = 1;
    else if (r1)
      m_next = 2;
    else
      m_next = 0;
  endtask

  task automatic model_step();
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (e_ack0) m_last = 0;
    if (e_ack1) m_last = 1;
    m_own = m_next;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(bit r0, bit w0, logic [7:0] a0, logic [7:0] d0,
                       bit r1, bit w1, logic [7:0] a1, logic [7:0] d1,
                       bit lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    m1_lock = lk;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_ack0"}, 32'(m0_ack), 32'd0);
    chk({tag, "_ack1"}, 32'(m1_ack), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single m0 read of 0x10
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // m1 write 0x20 <= 0xC3, then m0 read-back
    drive(0, 0, 0, 0, 1, 1, 8'h20, 8'hC3, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 8'h20, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // contention
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    repeat (6) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // m1 lock while m0 waits
    drive(0, 0, 0, 0, 1, 1, 8'h30, 8'h11, 1);
    cycle();
    drive(1, 0, 8'h30, 0, 1, 1, 8'h31, 8'h22, 1);
    repeat (4) cycle();
    drive(1, 0, 8'h30, 0, 1, 1, 8'h32, 8'h33, 0);
    cycle();
    drive(1, 0, 8'h31, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // abort in the owned cycle
    drive(1, 1, 8'h40, 8'hEE, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 8'h40, 8'hEE, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // reset in the middle of an m1 write
    drive(0, 0, 0, 0, 1, 1, 8'h50, 8'h77, 0);
    cycle();
    drive(1, 0, 8'h50, 0, 1, 1, 8'h50, 8'h77, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // random traffic with requests mostly held until acked
    for (int n = 0; n < 600; n++) begin
      bit p0, p1;
      p0 = m0_req && !e_ack0 && ($urandom_range(15) != 0);
      p1 = m1_req && !e_ack1 && ($urandom_range(15) != 0);
      if (!p0) begin
        m0_req   = $urandom_range(1);
        m0_we    = $urandom_range(1);
        m0_addr  = 8'($urandom_range(15));
        m0_wdata = 8'($urandom);
      end
      if (!p1) begin
        m1_req   = $urandom_range(1);
        m1_we    = $urandom_range(1);
        m1_addr  = 8'($urandom_range(15));
        m1_wdata = 8'($urandom);
      end
      m1_lock = ($urandom_range(2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master arbiter for the shared 8-bit data bus (data memory, LED and push-button address space) driven by `alu_out`/`reg_data0`. Master 0 is the CPU core; master 1 is a second requester (loader/debug port). The block registers ownership in a small state machine, acknowledges one transfer per owned cycle, and provides a stall signal so the CPU freezes its PC and register write while it waits.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_req`  in  1  CPU transfer request, held until `m0_ack`
- `m0_we`  in  1  CPU write (1) / read (0)
- `m0_addr`  in  ADDR_W  CPU address
- `m0_wdata`  in  DATA_W  CPU write data
- `m0_ack`  out  1  CPU transfer completes this cycle
- `m0_rdata`  out  DATA_W  CPU read data, valid while `m0_ack`
- `m0_stall`  out  1  `m0_req & ~m0_ack`; CPU holds PC, suppresses reg/mem write
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: same as m0 for master 1
- `m1_lock`  in  1  master 1 requests bus retention after current ack
- `bus_we`  out  1  write strobe to memory/LED
- `bus_addr`  out  ADDR_W  address to memory, LED, push-button decoder
- `bus_wdata`  out  DATA_W  write data to memory/LED
- `bus_rdata`  in  DATA_W  combinational read data from the address decoder mux
- `owner`  out  2  debug: 00 idle, 01 m0, 10 m1

## Operation
- States: IDLE, OWN0, OWN1 (registered, one-hot or binary). Register `last` (owner of most recent ack).
- IDLE: bus outputs all 0, no acks. Next state: OWNx for the winner among requesting masters; none → stay IDLE.
- OWNx: bus mux selects master x; `mx_ack = mx_req`; `bus_we = mx_req & mx_we`; `mx_rdata = bus_rdata` when `mx_ack`, else 0. Other master's ack/rdata = 0.
- Leaving OWNx (evaluated on current-cycle inputs):
  - OWN1 with `m1_req & m1_lock` → stay OWN1 (back-to-back acks, m0 blocked).
  - Else other master requesting → OWN(other).
  - Else x still requesting (next transfer already presented) → stay OWNx.
  - Else → IDLE.
- Aborted request: owner's req low in OWNx → no ack, no write, `last` unchanged, transitions as above.
- Arbitration when both request from IDLE: see Configuration. `last` updates only on an ack.
- `m1_lock` is ignored unless the block is in OWN1; it never pre-empts OWN0.
- Addresses and data pass through unmodified; no width conversion.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, `last`=1 (m0 wins first tie), `owner`=00; all acks, `bus_we`, `bus_addr`, `bus_wdata`, rdata outputs 0 immediately.
- Request-to-ack latency from IDLE: 1 cycle (req in cycle n → ack in n+1). Continuous ownership: ack in the same cycle req is seen.
- Write commits at the rising edge ending the ack cycle. Read data is combinational within the ack cycle.
- Ack, stall, bus outputs are combinational from state and req; no output registered beyond the state.
- Reset mid-transfer: `bus_we` drops asynchronously, in-flight write is lost, master must re-request.
- Simultaneous: both masters request while one is owned → ownership switches after one ack (lock excepted); no idle cycle inserted on a switch.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin; on a tie from IDLE, the master ≠ `last` wins; the same rule governs the "other requesting" switch in OWNx.
- Undefined: fixed priority, m0 always wins ties from IDLE; from OWN0 with both requesting, stay OWN0 (m1 waits until m0 idle); from OWN1, switch to m0 if requesting and not locked. `last` still maintained for the debug path.

## Test plan
- Reset: assert `rst_n`=0 with both reqs high mid-OWN1 → `owner`=00, `bus_we`=0, acks 0 same cycle; after release, both req → OWN0 first ack.
- Single m0 read: `m0_req`=1, addr 0x10, memory holds 0x5A → `m0_stall`=1 one cycle, next cycle `m0_ack`=1, `m0_rdata`=0x5A, `bus_we`=0.
- m1 write: addr 0x20, data 0xC3 → one cycle after req, `bus_we`=1, `bus_addr`=0x20; subsequent m0 read of 0x20 returns 0xC3.
- Contention with RR: both req continuously 6 cycles → acks alternate m0,m1,m0,m1,m0 after first idle cycle; with macro undefined → m0 acked every cycle, m1 never.
- Lock: m1 owns, `m1_lock`=1 for 4 transfers while m0 requests → four consecutive m1 acks, `m0_stall`=1 throughout; lock drop → m0 acked next cycle.
- Abort: m0 drops req in its OWN0 cycle → no ack, no write, state IDLE next cycle.
